// File: rtl/uart_frame_arbiter_pkg.sv
// Shared types and helpers for the UART frame arbiter: FSM encoding,
// frame width and the counter-width helper.
package uart_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arbState_t;

  localparam int BITS_PER_BYTE = 8;

  function automatic int frameWidth(input int byteNum);
    return BITS_PER_BYTE * byteNum;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clogb(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// Requester / frame-sender bundle of the UART frame arbiter.
// master = arbiter side, slave = requesters plus frame sender.
interface uart_frame_arbiter_if #(
  parameter int NUMREQ  = 4,
  parameter int BYTENUM = 7
);
  import uart_frame_arbiter_pkg::*;

  localparam int FRAME_W = frameWidth(BYTENUM);

  logic [NUMREQ-1:0]         req;
  logic [NUMREQ*FRAME_W-1:0] reqData;
  logic                      frameEnable;
  logic [FRAME_W-1:0]        frameData;
  logic                      frameDone;
  logic [NUMREQ-1:0]         grant;
  logic [NUMREQ-1:0]         ack;
  logic                      busy;
  logic                      timeoutErr;

  modport master (
    input  req, reqData, frameDone,
    output frameEnable, frameData, grant, ack, busy, timeoutErr
  );

  modport slave (
    output req, reqData, frameDone,
    input  frameEnable, frameData, grant, ack, busy, timeoutErr
  );

endinterface

// File: rtl/uart_frame_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward modulo N.
module rr_priority_picker
  import uart_frame_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clogb(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = PW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one UART frame sender among NUMREQ requesters.
// Optional watchdog abort of a stuck frame: define TIMEOUT_EN.
module uart_frame_arbiter
  import uart_frame_arbiter_pkg::*;
#(
  parameter int NUMREQ        = 4,
  parameter int BYTENUM       = 7,
  parameter int GAPCYCLES     = 2,
  parameter int TIMEOUTCYCLES = 200_000
) (
  input logic                 clk,
  input logic                 reset,
  uart_frame_arbiter_if.master bus
);

  localparam int FRAME_W = frameWidth(BYTENUM);
  localparam int PTR_W   = clogb(NUMREQ);
  localparam int GAP_W   = clogb(GAPCYCLES);

  if (NUMREQ < 2 || NUMREQ > 8 || GAPCYCLES < 1 || TIMEOUTCYCLES < 2) begin : gBadParams
    $error("uart_frame_arbiter: parameter out of range");
  end

  arbState_t          state, stateNext;
  logic               frameEnable, enNext;
  logic [FRAME_W-1:0] frameData, dataNext;
  logic [NUMREQ-1:0]  grant, grantNext;
  logic [NUMREQ-1:0]  ack, ackNext;
  logic               busy, busyNext;
  logic [PTR_W-1:0]   rrPtr, ptrNext;
  logic [PTR_W-1:0]   winIdx, winNext;
  logic [GAP_W-1:0]   gapCnt, gapNext;
  logic               endFrame;

  logic [NUMREQ-1:0]  pickOnehot;
  logic [PTR_W-1:0]   pickIdx;
  logic               pickAny;

  rr_priority_picker #(
    .N  (NUMREQ),
    .PW (PTR_W)
  ) uPicker (
    .req    (bus.req),
    .ptr    (rrPtr),
    .onehot (pickOnehot),
    .idx    (pickIdx),
    .any    (pickAny)
  );

`ifdef TIMEOUT_EN
  localparam int WD_W = clogb(TIMEOUTCYCLES);

  logic [WD_W-1:0] wdCnt, wdNext;
  logic            timeoutErr, toNext;
  logic            timeoutHit;

  assign timeoutHit = (wdCnt == WD_W'(TIMEOUTCYCLES - 1));
`endif

  always_comb begin
    stateNext = state;
    enNext    = frameEnable;
    dataNext  = frameData;
    grantNext = grant;
    ackNext   = '0;
    ptrNext   = rrPtr;
    winNext   = winIdx;
    gapNext   = gapCnt;
    endFrame  = 1'b0;
`ifdef TIMEOUT_EN
    wdNext    = wdCnt;
    toNext    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pickAny) begin
          stateNext = SEND;
          enNext    = 1'b1;
          dataNext  = bus.reqData[pickIdx*FRAME_W +: FRAME_W];
          grantNext = pickOnehot;
          winNext   = pickIdx;
`ifdef TIMEOUT_EN
          wdNext    = '0;
`endif
        end
      end
      SEND: begin
`ifdef TIMEOUT_EN
        endFrame = bus.frameDone || timeoutHit;
        toNext   = !bus.frameDone && timeoutHit;
        wdNext   = wdCnt + 1'b1;
`else
        endFrame = bus.frameDone;
`endif
        if (endFrame) begin
          stateNext       = GAP;
          enNext          = 1'b0;
          grantNext       = '0;
          ackNext[winIdx] = 1'b1;
          ptrNext         = (winIdx == PTR_W'(NUMREQ - 1)) ? '0 : winIdx + 1'b1;
          gapNext         = GAP_W'(GAPCYCLES - 1);
        end
      end
      GAP: begin
        // req is deliberately not looked at here; IDLE samples it afterwards.
        if (gapCnt == '0) begin
          stateNext = IDLE;
        end else begin
          gapNext = gapCnt - 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        enNext    = 1'b0;
        grantNext = '0;
      end
    endcase
    busyNext = (stateNext != IDLE);
  end

  // Registered outputs and arbitration state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frameEnable <= 1'b0;
      frameData   <= '0;
      grant       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      rrPtr       <= '0;
      winIdx      <= '0;
      gapCnt      <= '0;
    end else begin
      state       <= stateNext;
      frameEnable <= enNext;
      frameData   <= dataNext;
      grant       <= grantNext;
      ack         <= ackNext;
      busy        <= busyNext;
      rrPtr       <= ptrNext;
      winIdx      <= winNext;
      gapCnt      <= gapNext;
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdCnt      <= '0;
      timeoutErr <= 1'b0;
    end else begin
      wdCnt      <= wdNext;
      timeoutErr <= toNext;
    end
  end

  assign bus.timeoutErr = timeoutErr;
`else
  assign bus.timeoutErr = 1'b0;
`endif

  assign bus.frameEnable = frameEnable;
  assign bus.frameData   = frameData;
  assign bus.grant       = grant;
  assign bus.ack         = ack;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Randomized scoreboard bench for uart_frame_arbiter: requests are turned into an
// expected service order at issue time, a monitor checks each granted frame.
module tb_uart_frame_arbiter;

  localparam int NUMREQ        = 4;
  localparam int BYTENUM       = 7;
  localparam int GAPCYCLES     = 2;
  localparam int TIMEOUTCYCLES = 16;
  localparam int FW            = 8 * BYTENUM;

  typedef struct {
    int             idx;
    logic [FW-1:0]  data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_frame_arbiter_if #(.NUMREQ(NUMREQ), .BYTENUM(BYTENUM)) bus ();

  uart_frame_arbiter #(
    .NUMREQ        (NUMREQ),
    .BYTENUM       (BYTENUM),
    .GAPCYCLES     (GAPCYCLES),
    .TIMEOUTCYCLES (TIMEOUTCYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            total = 0;
  int            bad   = 0;
  exp_t          expQ[$];
  logic [FW-1:0] payload [NUMREQ];
  int            mPtr     = 0;
  bit            monOn    = 1'b0;
  bit            senderOn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic logic [FW-1:0] randData();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[FW-1:0];
  endfunction

  // One cycle; requesters drop req right after seeing their ack.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUMREQ; i++)
      if (bus.ack[i]) bus.req[i] = 1'b0;
  endtask

  task automatic drive(input logic [NUMREQ-1:0] mask);
    for (int i = 0; i < NUMREQ; i++) bus.reqData[i*FW +: FW] = payload[i];
    bus.req = mask;
  endtask

  // All requests raised together while idle: service follows the pointer cyclically.
  task automatic setReq(input logic [NUMREQ-1:0] mask);
    int last;
    last = -1;
    for (int k = 0; k < NUMREQ; k++) begin
      int r;
      r = (mPtr + k) % NUMREQ;
      if (mask[r]) begin
        expQ.push_back('{r, payload[r]});
        last = r;
      end
    end
    if (last >= 0) mPtr = (last + 1) % NUMREQ;
    drive(mask);
  endtask

  task automatic waitIdle(input string name, input int mutIdx);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      tick();
      if (mutIdx >= 0 && bus.frameEnable && bus.grant[mutIdx])
        bus.reqData[mutIdx*FW +: FW] = randData();
      if (bus.req == '0 && !bus.busy) done = 1'b1;
    end
    check({name, " reached idle"}, done, 1);
    check({name, " all frames seen"}, expQ.size(), 0);
  endtask

  task automatic waitAck(input string name, input logic [NUMREQ-1:0] want);
    for (int n = 0; n < 200 && bus.ack == '0; n++) tick();
    check(name, bus.ack, want);
  endtask

  // Frame sender: done some cycles after enable, plus stray pulses while idle.
  initial begin : sender
    int hold;
    hold = 0;
    bus.frameDone = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.frameDone) begin
        bus.frameDone = 1'b0;
      end else if (senderOn && bus.frameEnable) begin
        if (hold == 0) hold = int'($urandom_range(1, 6));
        hold--;
        if (hold == 0) bus.frameDone = 1'b1;
      end else if (senderOn && !bus.frameEnable && $urandom_range(0, 5) == 0) begin
        bus.frameDone = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t cur;
    bit   prevEn;
    bit   haveFrame;
    int   lowCnt;
    cur.idx   = 0;
    cur.data  = '0;
    prevEn    = 1'b0;
    haveFrame = 1'b0;
    lowCnt    = 0;
    forever begin
      @(negedge clk);
      if (!monOn) begin
        haveFrame = 1'b0;
        lowCnt    = 0;
      end else begin
        if (bus.frameEnable && !prevEn) begin
          if (haveFrame) check("enable-low gap long enough", lowCnt >= GAPCYCLES + 1, 1);
          if (expQ.size() == 0) begin
            check("unexpected grant", bus.grant, 0);
          end else begin
            cur = expQ.pop_front();
            check("grant", bus.grant, 64'(1) << cur.idx);
          end
          lowCnt    = 0;
          haveFrame = 1'b1;
        end
        if (bus.frameEnable) begin
          check("frameData", bus.frameData, cur.data);
          check("busy in frame", bus.busy, 1);
        end else begin
          lowCnt++;
        end
        if (bus.ack != '0)
          check("ack", bus.ack, (prevEn && !bus.frameEnable) ? (64'(1) << cur.idx) : 64'(0));
      end
      prevEn = bus.frameEnable;
    end
  end

  initial begin : guard
    #500_000;
    $display("FAIL global time limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [NUMREQ-1:0] m;
    bus.req     = '0;
    bus.reqData = '0;
    for (int i = 0; i < NUMREQ; i++) payload[i] = '0;

    repeat (3) @(negedge clk);
    check("reset frameEnable", bus.frameEnable, 0);
    check("reset grant", bus.grant, 0);
    check("reset ack", bus.ack, 0);
    check("reset busy", bus.busy, 0);
    check("reset timeoutErr", bus.timeoutErr, 0);
    check("reset frameData", bus.frameData, 0);
    reset    = 1'b1;
    monOn    = 1'b1;
    senderOn = 1'b1;

    for (int i = 0; i < NUMREQ; i++) payload[i] = randData();
    setReq(4'b1111);
    waitIdle("all four", -1);

    payload[0] = 56'h11223344556677;
    setReq(4'b0001);
    tick();
    check("enable one cycle after req", bus.frameEnable, 1);
    check("first payload", bus.frameData, 56'h11223344556677);
    check("first grant", bus.grant, 4'b0001);
    waitAck("single ack", 4'b0001);
    tick();
    check("gap cycle 1 low", bus.frameEnable, 0);
    tick();
    check("gap cycle 2 low", bus.frameEnable, 0);
    waitIdle("single", -1);

    payload[2] = randData();
    setReq(4'b0100);
    waitIdle("move pointer to 3", -1);
    payload[0] = randData();
    payload[3] = randData();
    setReq(4'b1001);
    waitIdle("pointer 3 with 1001", -1);

    payload[2] = randData();
    setReq(4'b0100);
    waitIdle("payload held", 2);

    repeat (12) begin
      for (int i = 0; i < NUMREQ; i++) payload[i] = randData();
      m = NUMREQ'($urandom_range(1, (1 << NUMREQ) - 1));
      setReq(m);
      waitIdle("random round", -1);
    end

    monOn      = 1'b0;
    senderOn   = 1'b0;
    payload[1] = randData();
    payload[2] = randData();
    drive(4'b0100);
    for (int n = 0; n < 20 && !bus.frameEnable; n++) tick();
    check("sending before reset", bus.frameEnable, 1);
    #2 reset = 1'b0;
    #1;
    check("mid-frame reset frameEnable", bus.frameEnable, 0);
    check("mid-frame reset grant", bus.grant, 0);
    check("mid-frame reset busy", bus.busy, 0);
    check("mid-frame reset frameData", bus.frameData, 0);
    check("mid-frame reset ack", bus.ack, 0);
    bus.req = 4'b0010;
    tick();
    reset = 1'b1;
    tick();
    check("grant after reset", bus.grant, 4'b0010);
    check("payload after reset", bus.frameData, payload[1]);
    senderOn = 1'b1;
    waitAck("ack after reset", 4'b0010);
    waitIdle("after reset", -1);
    mPtr  = 2;
    monOn = 1'b1;

    senderOn   = 1'b0;
    payload[3] = randData();
    setReq(4'b1000);
    for (int n = 0; n < 20 && !bus.frameEnable; n++) tick();
    check("stuck frame started", bus.frameEnable, 1);
`ifdef TIMEOUT_EN
    begin
      int cnt;
      cnt = 0;
      while (!bus.timeoutErr && cnt < 100) begin
        tick();
        cnt++;
      end
      check("timeout delay", cnt, TIMEOUTCYCLES);
      check("timeout ack", bus.ack, 4'b1000);
      check("timeout enable low", bus.frameEnable, 0);
      senderOn = 1'b1;
      waitIdle("after timeout", -1);
    end
`else
    repeat (40) tick();
    check("enable held without watchdog", bus.frameEnable, 1);
    check("no timeoutErr", bus.timeoutErr, 0);
    senderOn = 1'b1;
    waitIdle("stuck frame released", -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
